systolic_array_ctrl: RTL and testbench
======================================

// Module: systolic_array_ctrl
// PURPOSE
//  Job sequencer for VX_systolic_array (output-stationary N x N MAC grid).
//  - Accepts one A/B operand pair per valid/ready request and clears the array accumulators.
//  - Drives skewed row/column operand streams into the array, waits for the MAC pipeline to drain.
//  - Captures out_matrix into a result register and holds it under valid/ready until consumed.
// PARAMETERS
//  MATRIX_SIZE  3  N: array dimension; matrices are N x N.
//  DATA_SIZE    8  DW: element width; all arithmetic is modulo 2^DW, as in the array.
//  MAC_LAT      1  cycles from last operand at a MAC input to its out_sum being final.
// PORTS
//  clk        in   1           clock; all state on rising edge.
//  reset_n    in   1           asynchronous, active-low reset.
//  req_valid  in   1           job request valid.
//  req_ready  out  1           controller can accept a job (IDLE only).
//  req_a      in   N*N*DW      matrix A, row-major; element (r,c) at bits [(r*N+c)*DW +: DW].
//  req_b      in   N*N*DW      matrix B, same packing.
//  arr_clear  out  1           active-high reset into the array's reset pin.
//  arr_in_a   out  [N][DW]     row operands to array in_a.
//  arr_in_b   out  [N][DW]     column operands to array in_b.
//  arr_out    in   [N*N][DW]   array out_matrix, index r*N+c.
//  res_valid  out  1           result valid; held until res_ready.
//  res_ready  in   1           consumer accepts result.
//  res_data   out  N*N*DW      captured C = A*B, same packing as req_a.
//  busy       out  1           high in every state except IDLE.
// BEHAVIOUR
//  Reset (reset_n low, async): state=IDLE, step=0, req_ready=0 while low,
//    arr_clear=1, arr_in_a/b=0, res_valid=0, res_data=0, busy=0.
//  States:
//    IDLE  -> CLEAR  on req_valid&&req_ready; latch req_a/req_b into operand regs.
//    CLEAR -> FEED   after 1 cycle; arr_clear=1, feeds 0.
//    FEED  -> DRAIN  after FEED_CYCLES=3N-2 cycles; step t=0..3N-3.
//    DRAIN -> DONE   after MAC_LAT cycles; feeds 0. On the exit edge,
//                    res_data<=arr_out, res_valid<=1.
//    DONE  -> IDLE   on res_ready; res_valid<=0.
//  Feed skew (FEED only, else 0):
//    arr_in_a[i] = A[i][t-i] if 0<=t-i<N, else 0.
//    arr_in_b[j] = B[t-j][j] if 0<=t-j<N, else 0.
//    Driven combinationally from operand regs and step.
//  arr_clear: 1 in reset and CLEAR, 0 otherwise; accumulators are never cleared mid-job.
//  req_ready = (state==IDLE) && reset_n.
//    No accept while res_valid, so an unconsumed result is never overwritten.
//  Latency: accept edge k -> res_valid rises at edge k+1+(3N-2)+MAC_LAT (N=3, MAC_LAT=1: k+9).
//  res_data stable while res_valid=1 with res_ready=0; no timeout, holds indefinitely.
//  res_valid&&res_ready in DONE and req_valid in the same cycle:
//    the controller goes to IDLE first; the new job is accepted the next cycle (1-cycle bubble).
//  req_a/req_b may change after the accept edge without effect.
//  Reset mid-job: result discarded; the array is cleared via arr_clear; no partial res_valid.
//  step counter width: $clog2(3N-2+MAC_LAT+1); saturates never; reloads to 0 on every state entry.
// STRUCTURE
//  Shared package systolic_pkg:
//    - typedef enum logic [2:0] {SA_IDLE, SA_CLEAR, SA_FEED, SA_DRAIN, SA_DONE} sa_state_e;
//    - function sa_feed_cycles(N) = 3N-2;
//    - packing helper for element index r*N+c.
//  Sub-module systolic_skew_feeder: combinational; operand regs + step + feed_en -> arr_in_a/arr_in_b.
//  FSM, counter, operand and result registers stay in systolic_array_ctrl.
// TESTING (bench instantiates controller + VX_systolic_array, N=3, DW=8, MAC_LAT=1)
//  1. A=identity, B=1..9 row-major, res_ready=1 -> res_data=B, res_valid at accept+9, one pulse.
//  2. A=B=all 16 -> every C element = 3*256 mod 256 = 0 (wrap); A=B=all 2 -> all elements 12.
//  3. res_ready=0 for 20 cycles after res_valid -> res_data and res_valid stable, req_ready=0 throughout;
//     then res_ready=1 -> IDLE next cycle.
//  4. reset_n low at FEED step 3 for 2 cycles -> outputs at reset values immediately (async);
//     next job A=B=identity -> C=identity (no residue from the aborted job).
//  5. Back-to-back: req_valid held high with two jobs (A=1..9, B=identity) then (A=identity, B=9..1)
//     -> results 1..9 then 9..1, second accept exactly 1 cycle after first result handshake.
//  6. Check arr_in_a/arr_in_b every FEED cycle against the skew formula; verify all-zero outside FEED.

Source files
------------

// File: rtl/systolic_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : systolic_pkg
// Brief   : Shared state encoding and index helpers for the systolic job sequencer.
// Revision: 1.0
// ============================================================================
package systolic_pkg;

    typedef enum logic [2:0] {
        SA_IDLE,
        SA_CLEAR,
        SA_FEED,
        SA_DRAIN,
        SA_DONE
    } sa_state_e;

    // Skewed streams need 3N-2 steps before the last operand pair reaches PE(N-1,N-1).
    function automatic int sa_feed_cycles(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int sa_elem_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_array_ctrl_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module  : systolic_skew_feeder
// Brief   : Combinational diagonal-skew operand driver for the systolic array.
// Revision: 1.0
// ============================================================================
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 3,
    parameter int DATA_SIZE   = 8,
    parameter int STEP_W      = 4
) (
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] op_a,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] op_b,
    input  logic [STEP_W-1:0]                            step,
    input  logic                                         feed_en,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]        arr_in_a,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]        arr_in_b
);

    localparam int C_N  = MATRIX_SIZE;
    localparam int C_DW = DATA_SIZE;

    int w_k;

    // Lane i carries element k = t - i, so row i / column i start i steps late.
    always_comb begin
        arr_in_a = '0;
        arr_in_b = '0;
        w_k      = 0;
        for (int i = 0; i < C_N; i++) begin
            w_k = int'(step) - i;
            if (feed_en && (w_k >= 0) && (w_k < C_N)) begin
                arr_in_a[i] = op_a[sa_elem_idx(i, w_k, C_N)*C_DW +: C_DW];
                arr_in_b[i] = op_b[sa_elem_idx(w_k, i, C_N)*C_DW +: C_DW];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : systolic_array_ctrl
// Brief   : Job sequencer: clear, skew-feed, drain and capture one N x N product.
// Revision: 1.0
// ============================================================================
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 3,
    parameter int DATA_SIZE   = 8,
    parameter int MAC_LAT     = 1
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              req_valid,
    output logic                                              req_ready,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0]      req_a,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0]      req_b,
    output logic                                              arr_clear,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]             arr_in_a,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]             arr_in_b,
    input  logic [MATRIX_SIZE*MATRIX_SIZE-1:0][DATA_SIZE-1:0] arr_out,
    output logic                                              res_valid,
    input  logic                                              res_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0]      res_data,
    output logic                                              busy
);

    localparam int C_MW          = MATRIX_SIZE * MATRIX_SIZE * DATA_SIZE;
    localparam int C_FEED_CYCLES = sa_feed_cycles(MATRIX_SIZE);
    localparam int C_STEP_W      = $clog2(C_FEED_CYCLES + MAC_LAT + 1);
    localparam logic [C_STEP_W-1:0] C_FEED_LAST  = C_STEP_W'(C_FEED_CYCLES - 1);
    localparam logic [C_STEP_W-1:0] C_DRAIN_LAST = C_STEP_W'(MAC_LAT - 1);

    sa_state_e             r_state;
    logic [C_STEP_W-1:0]   r_step;
    logic [C_MW-1:0]       r_op_a;
    logic [C_MW-1:0]       r_op_b;
    logic                  w_feed_en;

    assign req_ready = (r_state == SA_IDLE) && reset_n;
    assign busy      = (r_state != SA_IDLE);
    assign w_feed_en = (r_state == SA_FEED);
    // The array is held in reset both while we are reset and for the clear cycle.
    assign arr_clear = !reset_n || (r_state == SA_CLEAR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= SA_IDLE;
            r_step    <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (r_state)
                SA_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_state <= SA_CLEAR;
                        r_step  <= '0;
                        r_op_a  <= req_a;
                        r_op_b  <= req_b;
                    end
                end
                SA_CLEAR: begin
                    r_state <= SA_FEED;
                    r_step  <= '0;
                end
                SA_FEED: begin
                    if (r_step == C_FEED_LAST) begin
                        r_state <= SA_DRAIN;
                        r_step  <= '0;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                SA_DRAIN: begin
                    if (r_step == C_DRAIN_LAST) begin
                        r_state   <= SA_DONE;
                        r_step    <= '0;
                        res_data  <= arr_out;
                        res_valid <= 1'b1;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                SA_DONE: begin
                    if (res_ready) begin
                        r_state   <= SA_IDLE;
                        r_step    <= '0;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= SA_IDLE;
                    r_step  <= '0;
                end
            endcase
        end
    end

    systolic_skew_feeder #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_SIZE   (DATA_SIZE),
        .STEP_W      (C_STEP_W)
    ) u_feeder (
        .op_a     (r_op_a),
        .op_b     (r_op_b),
        .step     (r_step),
        .feed_en  (w_feed_en),
        .arr_in_a (arr_in_a),
        .arr_in_b (arr_in_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_array_ctrl
// Brief   : Directed bench for the sequencer driving an output-stationary MAC grid model.
// Revision: 1.0
// ============================================================================
module tb_systolic_array_ctrl;

    localparam int N       = 3;
    localparam int DW      = 8;
    localparam int MAC_LAT = 1;
    localparam int MW      = N * N * DW;

    // Element k of a matrix sits at bits [k*8 +: 8]; element 0 is the rightmost byte.
    localparam logic [MW-1:0] M_ID   = 72'h01_00_00_00_01_00_00_00_01;
    localparam logic [MW-1:0] M_INC  = 72'h09_08_07_06_05_04_03_02_01;
    localparam logic [MW-1:0] M_DEC  = 72'h01_02_03_04_05_06_07_08_09;
    localparam logic [MW-1:0] M_16   = 72'h10_10_10_10_10_10_10_10_10;
    localparam logic [MW-1:0] M_2    = 72'h02_02_02_02_02_02_02_02_02;
    localparam logic [MW-1:0] M_12   = 72'h0c_0c_0c_0c_0c_0c_0c_0c_0c;
    localparam logic [MW-1:0] M_ZERO = '0;

    logic                      clk;
    logic                      reset_n;
    logic                      req_valid;
    logic                      req_ready;
    logic [MW-1:0]             req_a;
    logic [MW-1:0]             req_b;
    logic                      arr_clear;
    logic [N-1:0][DW-1:0]      arr_in_a;
    logic [N-1:0][DW-1:0]      arr_in_b;
    logic [N*N-1:0][DW-1:0]    arr_out;
    logic                      res_valid;
    logic                      res_ready;
    logic [MW-1:0]             res_data;
    logic                      busy;

    int checks   = 0;
    int failures = 0;

    systolic_array_ctrl #(
        .MATRIX_SIZE (N),
        .DATA_SIZE   (DW),
        .MAC_LAT     (MAC_LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .arr_clear (arr_clear),
        .arr_in_a  (arr_in_a),
        .arr_in_b  (arr_in_b),
        .arr_out   (arr_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    // Output-stationary grid: A moves right, B moves down, each PE accumulates a*b.
    logic [DW-1:0] a_q [N][N];
    logic [DW-1:0] b_q [N][N];
    logic [DW-1:0] s_q [N][N];
    logic [DW-1:0] a_w [N][N];
    logic [DW-1:0] b_w [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_w[i][0] = arr_in_a[i];
            b_w[0][i] = arr_in_b[i];
            for (int j = 1; j < N; j++) begin
                a_w[i][j] = a_q[i][j-1];
                b_w[j][i] = b_q[j-1][i];
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_out[i*N+j] = s_q[i][j];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_clear) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                    s_q[i][j] <= '0;
                end else begin
                    a_q[i][j] <= a_w[i][j];
                    b_q[i][j] <= b_w[i][j];
                    s_q[i][j] <= s_q[i][j] + a_w[i][j] * b_w[i][j];
                end
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {arr_in_b, arr_in_a} at feed step t.
    function automatic logic [2*N*DW-1:0] exp_feed(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                                   input int t);
        logic [N-1:0][DW-1:0] ea;
        logic [N-1:0][DW-1:0] eb;
        ea = '0;
        eb = '0;
        for (int i = 0; i < N; i++) begin
            if ((t - i >= 0) && (t - i < N)) begin
                ea[i] = a[(i*N + (t-i))*DW +: DW];
                eb[i] = b[((t-i)*N + i)*DW +: DW];
            end
        end
        return {eb, ea};
    endfunction

    // Starts at a falling edge in IDLE; returns at the falling edge of the first DONE cycle.
    task automatic run_job(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                           input logic [MW-1:0] exp, input bit keep_valid);
        check({tag, ".ready"}, 128'(req_ready), 128'(1'b1));
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
        req_a = ~a;
        req_b = ~b;
        check({tag, ".clear"}, 128'({busy, arr_clear, req_ready, arr_in_b, arr_in_a}),
              128'({3'b110, 48'd0}));
        for (int t = 0; t < 3*N-2; t++) begin
            @(negedge clk);
            check($sformatf("%s.skew%0d", tag, t), 128'({arr_clear, res_valid, arr_in_b, arr_in_a}),
                  128'({2'b00, exp_feed(a, b, t)}));
        end
        @(negedge clk);
        check({tag, ".drain"}, 128'({busy, res_valid, arr_clear, arr_in_b, arr_in_a}),
              128'({3'b100, 48'd0}));
        @(negedge clk);
        check({tag, ".done"}, 128'({res_valid, arr_in_b, arr_in_a, res_data}),
              128'({1'b1, 48'd0, exp}));
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        #3;
        check("reset", 128'({req_ready, arr_clear, busy, res_valid, arr_in_a, arr_in_b, res_data}),
              128'({4'b0100, 120'd0}));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_reset", 128'({req_ready, arr_clear, busy, res_valid}), 128'(4'b1000));

        // Identity times 1..9, single result pulse.
        res_ready = 1'b1;
        run_job("t1", M_ID, M_INC, M_INC, 1'b0);
        @(negedge clk);
        check("t1.pulse", 128'({res_valid, busy, req_ready}), 128'(3'b001));

        // Modulo wrap, then a plain product.
        run_job("t2a", M_16, M_16, M_ZERO, 1'b0);
        @(negedge clk);
        run_job("t2b", M_2, M_2, M_12, 1'b0);
        @(negedge clk);

        // Result held under back-pressure with a pending request.
        res_ready = 1'b0;
        run_job("t3", M_DEC, M_ID, M_DEC, 1'b0);
        req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("t3.hold%0d", c), 128'({res_valid, req_ready, busy, res_data}),
                  128'({3'b101, M_DEC}));
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("t3.release", 128'({res_valid, req_ready, busy}), 128'(3'b010));
        req_valid = 1'b0;

        // Abort in FEED step 3.
        req_a     = M_INC;
        req_b     = M_INC;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t4.feed3", 128'({arr_in_b, arr_in_a}), 128'(exp_feed(M_INC, M_INC, 3)));
        reset_n = 1'b0;
        #1;
        check("t4.async", 128'({req_ready, arr_clear, busy, res_valid, arr_in_a, arr_in_b, res_data}),
              128'({4'b0100, 120'd0}));
        @(negedge clk);
        @(negedge clk);
        check("t4.held", 128'({req_ready, arr_clear, busy, res_valid}), 128'(4'b0100));
        reset_n = 1'b1;
        #1;
        run_job("t4", M_ID, M_ID, M_ID, 1'b0);
        @(negedge clk);
        check("t4.idle", 128'({res_valid, busy}), 128'(2'b00));

        // Back-to-back with req_valid held high: one-cycle bubble.
        res_ready = 1'b1;
        run_job("t5a", M_INC, M_ID, M_INC, 1'b1);
        @(negedge clk);
        check("t5.bubble", 128'({busy, req_ready, res_valid}), 128'(3'b010));
        run_job("t5b", M_ID, M_DEC, M_DEC, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        check("t5.idle", 128'({busy, req_ready, res_valid}), 128'(3'b010));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
